// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and default timing constants for the PLL reset/lock supervisor.
package pll_rst_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } pll_rst_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_RST_HOLD      = 16;
   localparam int DEF_LOCK_TIMEOUT  = 50000;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 7;
   localparam int DEF_LOSS_FILTER   = 4;

   function automatic int max3(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_rst_ctrl_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Resets to 0 so an unknown input reads as "not locked".
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset and lock supervisor: resets the PLL, waits for stable lock, retries.
// Build option PLL_RST_CTRL_LOSS_FILTER_EN: deglitch lock loss while running.
module pll_rst_ctrl
   import pll_rst_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int RST_HOLD      = DEF_RST_HOLD,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int LOSS_FILTER   = DEF_LOSS_FILTER
) (
   input  logic refclk,
   input  logic rst_n,
   input  logic pll_locked,
   output logic pll_rst,
   output logic sys_rst_n,
   output logic lock_lost,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic pll_fail
);

   localparam int CNT_MAX = max3(RST_HOLD, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int LW = $clog2(LOSS_FILTER + 1);

   localparam logic [CW-1:0] LD_HOLD = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] LD_TMO  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] LD_STB  = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);

`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
   localparam int FLT_LEN = LOSS_FILTER;
`else
   localparam int FLT_LEN = 1;
`endif
   localparam logic [LW-1:0] FLT_LAST = LW'(FLT_LEN - 1);

   pll_rst_state_t state;
   logic [CW-1:0]  cnt;
   logic [RW-1:0]  retry_nxt;
   logic [LW-1:0]  lo_cnt;
   logic           lk_s;
   logic           lk;
   logic           loss;

   bit_sync #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk  (refclk),
      .rst_n(rst_n),
      .d    (pll_locked),
      .q    (lk_s)
   );

   // Retime so the FSM decides on a flopped copy of the synchronized lock.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lk <= 1'b0;
      end else begin
         lk <= lk_s;
      end
   end

   // With FLT_LEN of 1 this counter never advances and trims away.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lo_cnt <= '0;
      end else if (state != ST_RUN || lk) begin
         lo_cnt <= '0;
      end else if (!loss) begin
         lo_cnt <= lo_cnt + 1'b1;
      end
   end

   assign loss      = !lk && (lo_cnt == FLT_LAST);
   assign retry_nxt = retry_cnt + 1'b1;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_PLL_RST;
         cnt       <= LD_HOLD;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         lock_lost <= 1'b0;
         retry_cnt <= '0;
         pll_fail  <= 1'b0;
      end else begin
         unique case (state)
            ST_PLL_RST: begin
               if (cnt == '0) begin
                  state   <= ST_WAIT_LOCK;
                  cnt     <= LD_TMO;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lk) begin
                  state <= ST_STABLE;
                  cnt   <= LD_STB;
               end else if (cnt == '0) begin
                  retry_cnt <= retry_nxt;
                  if (retry_nxt == RETRY_LAST) begin
                     state    <= ST_FAIL;
                     pll_fail <= 1'b1;
                  end else begin
                     state   <= ST_PLL_RST;
                     cnt     <= LD_HOLD;
                     pll_rst <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STABLE: begin
               if (!lk) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= LD_TMO;
               end else if (cnt == '0) begin
                  state     <= ST_RUN;
                  sys_rst_n <= 1'b1;
                  retry_cnt <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RUN: begin
               if (loss) begin
                  state     <= ST_PLL_RST;
                  cnt       <= LD_HOLD;
                  pll_rst   <= 1'b1;
                  sys_rst_n <= 1'b0;
                  lock_lost <= 1'b1;
               end
            end
            ST_FAIL: begin
               state <= ST_FAIL;
            end
            default: begin
               state <= ST_PLL_RST;
               cnt   <= LD_HOLD;
               pll_rst <= 1'b1;
               sys_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl with small timing parameters.
module tb_pll_rst_ctrl;

   localparam int SYNC = 2;
   localparam int HOLD = 4;
   localparam int TMO  = 32;
   localparam int STB  = 8;
   localparam int MAXR = 2;
   localparam int LFLT = 4;
   localparam int REL  = SYNC + STB + 1;
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
   localparam int LOSS_LAT = SYNC + 1 + LFLT - 1;
`else
   localparam int LOSS_LAT = SYNC + 1;
`endif

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       lock_lost;
   logic [1:0] retry_cnt;
   logic       pll_fail;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   pll_rst_ctrl #(
      .SYNC_STAGES  (SYNC),
      .RST_HOLD     (HOLD),
      .LOCK_TIMEOUT (TMO),
      .STABLE_CYCLES(STB),
      .MAX_RETRIES  (MAXR),
      .LOSS_FILTER  (LFLT)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .lock_lost (lock_lost),
      .retry_cnt (retry_cnt),
      .pll_fail  (pll_fail)
   );

   always #10 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int id);
      case (id)
         0:       return pll_rst;
         1:       return sys_rst_n;
         2:       return pll_fail;
         default: return lock_lost;
      endcase
   endfunction

   // First edge index at which the output shows v, or -1 past the bound.
   task automatic wait_for(input int id, input logic v, input int bound,
                           output int t);
      t = -1;
      for (int i = 0; i <= bound; i++) begin
         if (sig(id) === v) begin
            t = cyc;
            break;
         end
         tick();
      end
   endtask

   // Raise lock d cycles from now; returns the first sampling edge.
   task automatic raise_lock(input int d, output int e0);
      tick(d);
      pll_locked = 1'b1;
      e0 = cyc + 1;
   endtask

   // Drop lock in RUN and return when the PLL reset pulse ends.
   task automatic force_loss(output int tf);
      int tr;
      pll_locked = 1'b0;
      wait_for(0, 1'b1, 40, tr);
      wait_for(0, 1'b0, 40, tf);
      chk("loss_hold", tf - tr, HOLD);
   endtask

   initial begin
      int t, t2, r, e0, d, k;
      int ks[3];

      tick(3);
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_sys_rst_n", sys_rst_n, 0);
      chk("rst_lock_lost", lock_lost, 0);
      chk("rst_retry", retry_cnt, 0);
      chk("rst_fail", pll_fail, 0);

      rst_n = 1'b1;
      r = cyc;
      wait_for(0, 1'b0, 40, t);
      chk("first_hold", t - r, HOLD);

      raise_lock(10, e0);
      wait_for(1, 1'b1, 200, t);
      chk("clean_release", t - e0, REL);
      chk("clean_retry", retry_cnt, 0);
      chk("clean_pll_rst", pll_rst, 0);

      tick(5);
      pll_locked = 1'b0;
      e0 = cyc + 1;
      tick(1);
      pll_locked = 1'b1;
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
      tick(20);
      chk("glitch_ignored", sys_rst_n, 1);
      chk("glitch_no_lost", lock_lost, 0);
      pll_locked = 1'b0;
      e0 = cyc + 1;
`endif
      wait_for(1, 1'b0, 40, t);
      chk("loss_latency", t - e0, LOSS_LAT);
      chk("loss_lost", lock_lost, 1);
      chk("loss_pll_rst", pll_rst, 1);
      pll_locked = 1'b0;
      t2 = t;
      wait_for(0, 1'b0, 40, t);
      chk("loss_pulse", t - t2, HOLD);

      d = $urandom_range(0, 20);
      raise_lock(d, e0);
      wait_for(1, 1'b1, 200, t);
      chk("relock_release", t - e0, REL);
      chk("lost_sticky", lock_lost, 1);

      ks[0] = 5;
      ks[1] = 8;
      ks[2] = $urandom_range(1, 8);
      for (int i = 0; i < 3; i++) begin
         force_loss(t);
         k = ks[i];
         d = $urandom_range(0, 15);
         raise_lock(d, e0);
         tick(k);
         pll_locked = 1'b0;
         tick(1);
         pll_locked = 1'b1;
         wait_for(1, 1'b1, 200, t);
         chk("chatter_release", t - (e0 + k + 1), REL);
         chk("chatter_retry", retry_cnt, 0);
      end

      force_loss(t);
      wait_for(0, 1'b1, TMO + 10, t2);
      chk("timeout_len", t2 - t, TMO);
      chk("timeout_retry", retry_cnt, 1);
      wait_for(0, 1'b0, 40, t);
      chk("retry_hold", t - t2, HOLD);
      d = $urandom_range(0, 20);
      raise_lock(d, e0);
      wait_for(1, 1'b1, 200, t);
      chk("retry_release", t - e0, REL);
      chk("retry_cleared", retry_cnt, 0);

      force_loss(t);
      wait_for(0, 1'b1, TMO + 10, t);
      wait_for(0, 1'b0, 40, t);
      chk("mid_retry", retry_cnt, 1);
      tick(3);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_pll_rst", pll_rst, 1);
      chk("mid_retry_clr", retry_cnt, 0);
      chk("mid_lost_clr", lock_lost, 0);
      chk("mid_sys_rst_n", sys_rst_n, 0);
      tick(2);
      rst_n = 1'b1;
      r = cyc;
      wait_for(0, 1'b0, 40, t);
      chk("mid_hold", t - r, HOLD);

      wait_for(2, 1'b1, (MAXR + 1) * (TMO + HOLD), t2);
      chk("fail_time", t2 - t, MAXR * TMO + (MAXR - 1) * HOLD);
      chk("fail_pll_rst", pll_rst, 0);
      chk("fail_sys_rst_n", sys_rst_n, 0);
      chk("fail_retry", retry_cnt, MAXR);
      pll_locked = 1'b1;
      tick(60);
      chk("fail_held", pll_fail, 1);
      chk("fail_held_rst", pll_rst, 0);
      chk("fail_held_sys", sys_rst_n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

PLL-side reset and lock supervisor for the game's clock tree. Runs on the 50 MHz board reference clock and drives the PLL's active-high `rst` input. It consumes the PLL's asynchronous `locked` output and releases a clean system reset only after lock has been stable. On lock loss it re-resets the PLL, with a bounded retry count.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `pll_locked`; minimum 2.
- `RST_HOLD`, 16: refclk cycles `pll_rst` is held high per reset attempt; minimum 1.
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed for lock after `pll_rst` falls (1 ms).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 7: failed lock attempts tolerated before declaring failure; minimum 1.
- `LOSS_FILTER`, 4: consecutive low cycles that count as lock loss (used only with the filter macro).
- `refclk  in  1`: 50 MHz reference clock; the only clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `pll_locked  in  1`: PLL `locked`; asynchronous to `refclk`.
- `pll_rst  out  1`: active-high reset to the PLL.
- `sys_rst_n  out  1`: active-low system reset for the 25 MHz domains (registered).
- `lock_lost  out  1`: sticky; set on any lock loss while in RUN.
- `retry_cnt  out  $clog2(MAX_RETRIES+1)`: failed attempts since the last RUN.
- `pll_fail  out  1`: set when the retry budget is exhausted.

## Operation
- FSM states: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL.
- A single shared down-counter `cnt`, sized for the largest of RST_HOLD, LOCK_TIMEOUT and STABLE_CYCLES, is reloaded on every state entry.
- **PLL_RST** (entered from reset): `pll_rst`=1, `sys_rst_n`=0.
  - When `cnt` expires after RST_HOLD cycles, go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `sys_rst_n`=0.
  - If synchronized lock `lk`=1, go to STABLE.
  - If LOCK_TIMEOUT expires first, `retry_cnt`++.
  - If the new value equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- **STABLE**: while `lk`=1, count STABLE_CYCLES, then go to RUN.
  - If `lk`=0 at any point, return to WAIT_LOCK. The timeout restarts and `retry_cnt` is unchanged.
- **RUN**: `sys_rst_n`=1 and `retry_cnt` cleared to 0.
  - Lock loss: set `lock_lost`, force `sys_rst_n`=0, go to PLL_RST.
- **FAIL**: `pll_rst`=0, `sys_rst_n`=0, `pll_fail`=1.
  - Terminal; only `rst_n` exits.
- Simultaneous events:
  - Timeout and `lk` rising in the same cycle: lock wins, go to STABLE.
  - Lock loss in the same cycle STABLE would complete: loss wins, go to WAIT_LOCK.
- `lock_lost` clears only on `rst_n`.

## Timing
- Reset values: `pll_rst`=1, `sys_rst_n`=0, `lock_lost`=0, `retry_cnt`=0, `pll_fail`=0, state=PLL_RST.
- All outputs are registered. `rst_n` assertion forces reset values asynchronously. Deassertion is assumed synchronized upstream.
- `pll_rst` is high for exactly RST_HOLD cycles per attempt.
- Lock-to-release latency: `sys_rst_n` rises SYNC_STAGES + STABLE_CYCLES + 1 edges after the edge that first samples `pll_locked`=1.
- Loss-to-reset latency: `sys_rst_n` falls SYNC_STAGES + 1 edges after the first sampled low. With the filter enabled, add LOSS_FILTER − 1.
- Reset mid-attempt: all counters and state restart, and `retry_cnt` returns to 0.

## Configuration
- Macro: `PLL_RST_CTRL_LOSS_FILTER_EN`.
- Defined: lock loss in RUN requires `lk`=0 for LOSS_FILTER consecutive cycles. Shorter low pulses are ignored and do not set `lock_lost`.
- Undefined: a single low cycle of `lk` in RUN is a loss. The LOSS_FILTER parameter is unused.
- The STABLE and WAIT_LOCK behaviour is identical in both builds.

## Structure
- Package `pll_rst_ctrl_pkg`: the state enum `pll_rst_state_t` and the default constants for the timing parameters.
- One sub-module, `bit_sync`: a parameterized SYNC_STAGES-deep synchronizer with async active-low reset and reset value 0, used for `pll_locked`.

## Test plan
Bench parameters: RST_HOLD=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean lock: lock raised 10 cycles after `pll_rst` falls -> `sys_rst_n` rises 11 edges after the first high sample; `retry_cnt`=0.
- Timeout retry: lock never raised in the first attempt, raised in the second -> `retry_cnt`=1 after the first timeout, one extra 4-cycle `pll_rst` pulse, then release and `retry_cnt`=0.
- Failure: lock never raised -> after 2 timeouts `pll_fail`=1, `pll_rst`=0, `sys_rst_n`=0 held indefinitely.
- Chatter in STABLE: lock drops for 1 cycle at stable count 5 -> returns to WAIT_LOCK; release only after 8 fresh consecutive cycles.
- Loss in RUN: 1-cycle low pulse -> without the macro, `lock_lost`=1, `sys_rst_n` falls 3 edges later, `pll_rst` pulses for 4 cycles. With the macro, no effect; a 4-cycle low produces the loss.
- `rst_n` pulsed mid-WAIT_LOCK with `retry_cnt`=1 -> immediate `pll_rst`=1 and `retry_cnt`=0.
